spi_slave_bridge: RTL and testbench
===================================

SPI_SLAVE_BRIDGE -- requirements
Module: spi_slave_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, RX FIFO entries; power of two, 2..16.
REQ-002 block_clk_i  in  1  sole clock; all state on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 spi_sclk_i  in  1  SPI clock from master, asynchronous to block_clk_i.
REQ-005 spi_ss_i  in  1  slave select, active-low, asynchronous.
REQ-006 spi_mosi_i  in  1  serial data from master.
REQ-007 spi_miso_o  out  1  serial data to master.
REQ-008 rx_data_o  out  8  head byte of RX FIFO.
REQ-009 rx_valid_o  out  1  RX FIFO non-empty.
REQ-010 rx_ready_i  in  1  consumer pop; a pop occurs when rx_valid_o and rx_ready_i are both high at a clock edge.
REQ-011 tx_data_i  in  8  next byte to return on MISO.
REQ-012 tx_valid_i  in  1  tx_data_i offered.
REQ-013 tx_ready_o  out  1  TX holding register empty; a load occurs when tx_valid_i and tx_ready_o are both high.
REQ-014 overrun_o  out  1  sticky; a received byte was dropped.
REQ-015 overrun_clr_i  in  1  clears overrun_o.

Function
REQ-016 spi_sclk_i, spi_ss_i and spi_mosi_i SHALL each pass through a 2-flop synchronizer, plus a third flop for sclk/ss edge detection.
REQ-017 Supported sclk frequency SHALL be at most block_clk_i/4; SPI mode 0, MSB first, 8-bit bytes.
REQ-018 State machine IDLE/ACTIVE: IDLE->ACTIVE on synchronized ss falling edge; ACTIVE->IDLE on synchronized ss rising edge.
REQ-019 On IDLE->ACTIVE: bit counter = 0; TX shift register loads the holding register (holding marked empty) if full, else 0x00.
REQ-020 In ACTIVE, on each synchronized sclk rising edge, the synchronized MOSI bit SHALL shift into RX shift register LSB and the bit counter SHALL increment modulo 8.
REQ-021 The rising edge completing bit 7 SHALL push the assembled byte into the RX FIFO in the same cycle; rx_valid_o SHALL be high after the 2nd block_clk edge following the first edge that samples spi_sclk_i high.
REQ-022 Push while FIFO full and no simultaneous pop: byte dropped, overrun_o set; push and pop in the same cycle when full: both accepted.
REQ-023 overrun_o set has priority over overrun_clr_i in the same cycle.
REQ-024 spi_miso_o SHALL equal TX shift register MSB while ACTIVE, and 0 in IDLE.
REQ-025 On each synchronized sclk falling edge in ACTIVE, the TX shift register shifts left one bit; the falling edge after bit 7 reloads it per REQ-019.
REQ-026 ss deasserted mid-byte: partial RX byte discarded (no push), counter reset, TX shift register discarded; holding register unaffected.
REQ-027 rx_data_o SHALL be first-word-fall-through; rx_data_o is undefined when rx_valid_o is low.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH with a separate count to distinguish full from empty.

Reset
REQ-029 While rst_i is high: state IDLE, FIFO empty, rx_valid_o=0, rx_data_o=0x00, tx_ready_o=1, overrun_o=0, spi_miso_o=0, synchronizers cleared to ss=1, sclk=0, mosi=0.
REQ-030 Reset asserted mid-byte SHALL abandon the transfer; after release the block waits in IDLE for a new ss falling edge.

Configuration
REQ-031 Macro SPI_SLAVE_ECHO_EN: when defined, a reload with an empty holding register SHALL load the most recently pushed RX byte (0x00 after reset); when undefined, it loads 0x00.

Verification
REQ-032 Reset, ss low, 16 sclk cycles shifting 0x11 then 0x08 -> rx_valid_o; pops return 0x11, 0x08; overrun_o=0.
REQ-033 tx_data_i=0xA5 loaded before ss falls, master clocks 8 bits -> MISO sequence 1,0,1,0,0,1,0,1; tx_ready_o returns high at ss fall.
REQ-034 rx_ready_i held low, 5 bytes 0x01..0x05 (FIFO_DEPTH=4) -> pops return 0x01..0x04, overrun_o=1; overrun_clr_i pulse -> 0.
REQ-035 ss raised after 5 bits of 0xFF, then full byte 0x3C -> only 0x3C appears in FIFO.
REQ-036 SPI_SLAVE_ECHO_EN defined, no TX load, bytes 0x5A then 0x00 sent -> second byte's MISO is 0x5A; undefined -> 0x00.
REQ-037 rst_i pulsed after 4 bits of a byte -> all outputs at reset values; next full byte 0x77 received correctly.

Source files
------------

// File: rtl/spi_slave_bridge.sv
// spi_slave_bridge: SPI mode-0 slave into a byte FIFO plus a one-byte MISO holding register; RX byte visible 2 clocks after the synced last sclk rise.
// No SPI-side backpressure (a byte arriving at a full FIFO is dropped and flagged on overrun_o); `SPI_SLAVE_ECHO_EN` makes an empty TX reload return the last RX byte.
module spi_slave_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       block_clk_i,
  input  logic       rst_i,
  input  logic       spi_sclk_i,
  input  logic       spi_ss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       overrun_o,
  input  logic       overrun_clr_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e          state_q;
  logic [2:0]      sclk_sync_q;
  logic [2:0]      ss_sync_q;
  logic [1:0]      mosi_sync_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      rx_sr_q;
  logic [7:0]      rx_sr_d;
  logic [7:0]      tx_sr_q;
  logic [7:0]      tx_hold_q;
  logic            tx_full_q;
  logic            overrun_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
`ifdef SPI_SLAVE_ECHO_EN
  logic [7:0]      last_rx_q;
`endif

  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic       active, byte_done, pop, full, push_ok, drop, reload, tx_load;
  logic [7:0] empty_fill, reload_val;

  always_comb begin
    sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
    ss_fall    = ~ss_sync_q[1] & ss_sync_q[2];
    ss_rise    = ss_sync_q[1] & ~ss_sync_q[2];
    active     = (state_q == ACTIVE);
    rx_sr_d    = {rx_sr_q[6:0], mosi_sync_q[1]};
    byte_done  = active & ~ss_rise & sclk_rise & (bit_cnt_q == 3'd7);
    pop        = rx_valid_o & rx_ready_i;
    full       = (count_q == FULL_CNT);
    push_ok    = byte_done & (~full | pop);
    drop       = byte_done & full & ~pop;
    // A falling edge with the counter at zero can only follow a completed byte (mode 0 idles low).
    reload     = (~active & ss_fall) | (active & ~ss_rise & sclk_fall & (bit_cnt_q == 3'd0));
    tx_load    = tx_valid_i & ~tx_full_q;
`ifdef SPI_SLAVE_ECHO_EN
    empty_fill = last_rx_q;
`else
    empty_fill = 8'h00;
`endif
    reload_val = tx_full_q ? tx_hold_q : empty_fill;
  end

  always_ff @(posedge block_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      tx_hold_q   <= 8'h00;
      tx_full_q   <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef SPI_SLAVE_ECHO_EN
      last_rx_q   <= 8'h00;
`endif
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk_i};
      ss_sync_q   <= {ss_sync_q[1:0], spi_ss_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};

      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q   <= ACTIVE;
            bit_cnt_q <= 3'd0;
            rx_sr_q   <= 8'h00;
            tx_sr_q   <= reload_val;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            rx_sr_q   <= 8'h00;
            tx_sr_q   <= 8'h00;
          end else if (sclk_rise) begin
            rx_sr_q   <= rx_sr_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end else if (sclk_fall) begin
            tx_sr_q   <= reload ? reload_val : {tx_sr_q[6:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase

      if (reload && tx_full_q) begin
        tx_full_q <= 1'b0;
      end else if (tx_load) begin
        tx_hold_q <= tx_data_i;
        tx_full_q <= 1'b1;
      end

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end

      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

`ifdef SPI_SLAVE_ECHO_EN
      if (byte_done) last_rx_q <= rx_sr_d;
`endif
    end
  end

  always_ff @(posedge block_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_sr_d;
  end

  assign rx_valid_o = (count_q != '0);
  assign rx_data_o  = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign tx_ready_o = ~tx_full_q;
  assign overrun_o  = overrun_q;
  assign spi_miso_o = active & tx_sr_q[7];

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge: SPI master bit-banged from block_clk negedges, outputs sampled on negedges.
module tb_spi_slave_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, ss, mosi;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       overrun, overrun_clr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_slave_bridge #(.FIFO_DEPTH(4)) dut (
    .block_clk_i   (clk),
    .rst_i         (rst),
    .spi_sclk_i    (sclk),
    .spi_ss_i      (ss),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr)
  );

  // Clocks n bits of b MSB first; MISO is captured just before each rising edge.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] m);
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      repeat (4) @(negedge clk);
      m[7-i] = miso;
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic set_ss(input logic v);
    ss = v;
    repeat (8) @(negedge clk);
  endtask

  task automatic pop_byte(output logic [7:0] d);
    d = rx_data;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso got=%b want=0", miso); end
  endtask

  task automatic test_basic_rx;
    logic [7:0] m, d;
    set_ss(1'b0);
    spi_bits(8'h11, 8, m);
    spi_bits(8'h08, 8, m);
    set_ss(1'b1);
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%b want=1", rx_valid); end
    pop_byte(d);
    vectors++; if (d !== 8'h11) begin miscompares++; $display("FAIL basic_pop0 got=%h want=11", d); end
    pop_byte(d);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL basic_pop1 got=%h want=08", d); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL basic_empty got=%b want=0", rx_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL basic_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_tx;
    logic [7:0] m, d;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL tx_hold_full got=%b want=0", tx_ready); end
    set_ss(1'b0);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL tx_ready_at_ss got=%b want=1", tx_ready); end
    spi_bits(8'h00, 8, m);
    set_ss(1'b1);
    vectors++; if (m !== 8'hA5) begin miscompares++; $display("FAIL tx_miso_seq got=%h want=a5", m); end
    vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL tx_miso_idle got=%b want=0", miso); end
    pop_byte(d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL tx_rx_byte got=%h want=00", d); end
  endtask

  task automatic test_overrun;
    logic [7:0] m, d;
    set_ss(1'b0);
    for (int i = 1; i <= 5; i++) spi_bits(8'(i), 8, m);
    set_ss(1'b1);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set got=%b want=1", overrun); end
    for (int i = 1; i <= 4; i++) begin
      pop_byte(d);
      vectors++; if (d !== 8'(i)) begin miscompares++; $display("FAIL ovr_pop%0d got=%h want=%h", i, d, 8'(i)); end
    end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_empty got=%b want=0", rx_valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got=%b want=0", overrun); end
  endtask

  task automatic test_abort;
    logic [7:0] m, d;
    set_ss(1'b0);
    spi_bits(8'hFF, 5, m);
    set_ss(1'b1);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL abort_nopush got=%b want=0", rx_valid); end
    set_ss(1'b0);
    spi_bits(8'h3C, 8, m);
    set_ss(1'b1);
    pop_byte(d);
    vectors++; if (d !== 8'h3C) begin miscompares++; $display("FAIL abort_byte got=%h want=3c", d); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL abort_single got=%b want=0", rx_valid); end
  endtask

  task automatic test_echo;
    logic [7:0] m, d, exp;
`ifdef SPI_SLAVE_ECHO_EN
    exp = 8'h5A;
`else
    exp = 8'h00;
`endif
    set_ss(1'b0);
    spi_bits(8'h5A, 8, m);
    spi_bits(8'h00, 8, m);
    set_ss(1'b1);
    vectors++; if (m !== exp) begin miscompares++; $display("FAIL echo_miso got=%h want=%h", m, exp); end
    pop_byte(d);
    vectors++; if (d !== 8'h5A) begin miscompares++; $display("FAIL echo_pop0 got=%h want=5a", d); end
    pop_byte(d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL echo_pop1 got=%h want=00", d); end
  endtask

  task automatic test_latency;
    logic [7:0] m, d;
    set_ss(1'b0);
    spi_bits(8'hC3, 7, m);
    mosi = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    @(negedge clk);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL lat_edge0 got=%b want=0", rx_valid); end
    @(negedge clk);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL lat_edge1 got=%b want=0", rx_valid); end
    @(negedge clk);
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL lat_edge2 got=%b want=1", rx_valid); end
    repeat (6) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    set_ss(1'b1);
    pop_byte(d);
    vectors++; if (d !== 8'hC3) begin miscompares++; $display("FAIL lat_byte got=%h want=c3", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] m, d;
    set_ss(1'b0);
    spi_bits(8'h99, 8, m);
    spi_bits(8'hF0, 4, m);
    tx_data = 8'h81;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_pre_ready got=%b want=0", tx_ready); end
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_valid got=%b want=1", rx_valid); end
    rst = 1'b1;
    ss = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got=%b want=0", rx_valid); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rmid_data got=%h want=00", rx_data); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready got=%b want=1", tx_ready); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rmid_overrun got=%b want=0", overrun); end
    vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL rmid_miso got=%b want=0", miso); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    set_ss(1'b0);
    spi_bits(8'h77, 8, m);
    set_ss(1'b1);
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_post_valid got=%b want=1", rx_valid); end
    pop_byte(d);
    vectors++; if (d !== 8'h77) begin miscompares++; $display("FAIL rmid_post_byte got=%h want=77", d); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_post_empty got=%b want=0", rx_valid); end
  endtask

  initial begin
    rst = 1'b1;
    sclk = 1'b0;
    ss = 1'b1;
    mosi = 1'b0;
    rx_ready = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_basic_rx();
    test_tx();
    test_overrun();
    test_abort();
    test_echo();
    test_latency();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
